// File: rtl/apb_pkg.sv
// apb_pkg: shared APB state encodings and default bus widths for apb_master and the apb slave.
package apb_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } apb_state_e;
    localparam int DATAWIDTH_DEF = 32;
    localparam int ADDWIDTH_DEF  = 32;
endpackage

// File: rtl/apb_wait_cnt.sv
// apb_wait_cnt: ACCESS wait-state counter; hit_o fires in the wait cycle that brings the count to TIMEOUT_CYC.
//   clk    in  clock
//   rst    in  asynchronous active-low reset
//   clr_i  in  clear count (entry to ACCESS)
//   inc_i  in  count one wait cycle
//   hit_o  out this wait cycle reaches TIMEOUT_CYC
module apb_wait_cnt #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic inc_i,
    output logic hit_o
);
    localparam int W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clr_i ? '0 : inc_i ? cnt_q + 1'b1 : cnt_q;
    assign hit_o = inc_i && cnt_q == LAST;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/apb_master.sv
// apb_master: single-outstanding APB requester; optional ACCESS timeout under APB_MASTER_TIMEOUT_EN.
//   clk, rst                       clock, asynchronous active-low reset
//   req_valid/req_ready            request handshake (ready only in IDLE)
//   req_write/req_addr/req_wdata   request payload, captured on acceptance
//   rsp_valid/rsp_rdata/rsp_err    one-cycle completion pulse, read data, timeout abort flag
//   psel/pen/pwrite/paddr/pwdata   APB requester outputs, all registered
//   pready/prdata                  APB slave response, sampled only in ACCESS
module apb_master
    import apb_pkg::*;
#(
    parameter int DATAWIDTH   = DATAWIDTH_DEF,
    parameter int ADDWIDTH    = ADDWIDTH_DEF,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [ADDWIDTH-1:0]  req_addr,
    input  logic [DATAWIDTH-1:0] req_wdata,
    output logic                 rsp_valid,
    output logic [DATAWIDTH-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic                 psel,
    output logic                 pen,
    output logic                 pwrite,
    output logic [ADDWIDTH-1:0]  paddr,
    output logic [DATAWIDTH-1:0] pwdata,
    input  logic                 pready,
    input  logic [DATAWIDTH-1:0] prdata
);
    apb_state_e state_q, state_d;
    logic write_q, write_d, rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d, timeout_hit;
    logic [ADDWIDTH-1:0] addr_q, addr_d;
    logic [DATAWIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("apb_master: TIMEOUT_CYC must be >= 1");
    end
`ifdef APB_MASTER_TIMEOUT_EN
    apb_wait_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wait_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (state_q == SETUP),
        .inc_i (state_q == ACCESS && !pready),
        .hit_o (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif
    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    state_d = SETUP;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                // pready wins over a timeout landing in the same cycle
                if (pready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rdata_d     = write_q ? rdata_q : prdata;
                end else if (timeout_hit) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
        end
    end
    assign req_ready = state_q == IDLE;
    assign psel      = state_q == SETUP || state_q == ACCESS;
    assign pen       = state_q == ACCESS;
    assign pwrite    = write_q;
    assign paddr     = addr_q;
    assign pwdata    = wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: randomized and directed bench for apb_master against a transaction-level model and APB slave memory.
module tb_apb_master;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 4;
`ifdef APB_MASTER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b0;
    logic req_valid = 1'b0, req_write = 1'b0, pready = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic req_ready, rsp_valid, rsp_err, psel, pen, pwrite;
    logic [DW-1:0] rsp_rdata, pwdata, prdata;
    logic [AW-1:0] paddr;
    apb_master #(.DATAWIDTH(DW), .ADDWIDTH(AW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .pen(pen), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .pready(pready), .prdata(prdata)
    );
    always #5 clk = ~clk;
    int n_checks = 0, n_pass = 0;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask
    // APB slave: word memory indexed by paddr[5:2], written on a completing write
    logic [DW-1:0] smem [16];
    assign prdata = smem[paddr[5:2]];
    initial begin
        for (int i = 0; i < 16; i++) smem[i] = '0;
        forever begin
            @(negedge clk);
            if (rst && psel && pen && pready && pwrite) smem[paddr[5:2]] = pwdata;
        end
    end
    // Transaction-level model: one request in flight, one setup cycle, then access until pready or timeout
    bit busy = 1'b0, in_access = 1'b0, e_rv = 1'b0, e_err = 1'b0, m_write = 1'b0;
    int stalls = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0, e_rdata = '0;
    logic [DW-1:0] refmem [16];
    initial begin
        for (int i = 0; i < 16; i++) refmem[i] = '0;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                busy = 0; in_access = 0; stalls = 0; e_rv = 0; e_err = 0;
                m_write = 0; m_addr = '0; m_wdata = '0; e_rdata = '0;
            end else begin
                e_rv = 0;
                e_err = 0;
                if (!busy) begin
                    if (req_valid) begin
                        busy = 1; in_access = 0; stalls = 0;
                        m_write = req_write; m_addr = req_addr; m_wdata = req_wdata;
                    end
                end else if (!in_access) in_access = 1;
                else if (pready) begin
                    busy = 0; e_rv = 1;
                    if (m_write) refmem[m_addr[5:2]] = m_wdata;
                    else e_rdata = refmem[m_addr[5:2]];
                end else begin
                    stalls++;
                    if (TO_EN && stalls == TO) begin
                        busy = 0; e_rv = 1; e_err = 1;
                    end
                end
            end
        end
    end
    bit cmp_en = 1'b0;
    initial forever begin
        @(negedge clk);
        if (rst && cmp_en) begin
            chk("m_req_ready", req_ready, !busy);
            chk("m_psel", psel, busy);
            chk("m_pen", pen, busy && in_access);
            chk("m_rsp_valid", rsp_valid, e_rv);
            chk("m_rsp_err", rsp_err, e_err);
            chk("m_rsp_rdata", rsp_rdata, e_rdata);
            chk("m_paddr", paddr, m_addr);
            chk("m_pwrite", pwrite, m_write);
            chk("m_pwdata", pwdata, m_wdata);
        end
    end
    bit rand_pready = 1'b0;
    initial forever begin
        @(posedge clk);
        #2;
        if (rand_pready) pready = $urandom_range(0, 3) != 0;
    end
    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    endtask
    initial begin
        int rv_cnt;
        int b;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_psel", psel, 0);
        chk("rst_pen", pen, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        rst = 1'b1;
        cmp_en = 1'b1;
        cyc();
        // write 0xDEADBEEF to 0x4 with zero wait states
        pready = 1'b1;
        issue(1'b1, 32'h4, 32'hDEADBEEF);
        chk("t1_ready", req_ready, 1);
        cyc();
        req_valid = 1'b0;
        chk("t1_setup_psel", psel, 1);
        chk("t1_setup_pen", pen, 0);
        chk("t1_setup_paddr", paddr, 32'h4);
        chk("t1_setup_pwrite", pwrite, 1);
        cyc();
        chk("t1_access_pen", pen, 1);
        cyc();
        chk("t1_rsp_valid", rsp_valid, 1);
        chk("t1_rsp_err", rsp_err, 0);
        chk("t1_req_ready", req_ready, 1);
        chk("t1_psel_drop", psel, 0);
        cyc();
        // read back 0x4
        issue(1'b0, 32'h4, 32'h12345678);
        cyc();
        req_valid = 1'b0;
        chk("t2_setup_pwrite", pwrite, 0);
        chk("t2_pwdata", pwdata, 32'h12345678);
        cyc();
        chk("t2_access_pwrite", pwrite, 0);
        cyc();
        chk("t2_rsp_valid", rsp_valid, 1);
        chk("t2_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
        cyc();
        // three wait states then pready
        pready = 1'b0;
        issue(1'b1, 32'h8, 32'hA5A5A5A5);
        cyc();
        req_valid = 1'b0;
        cyc();
        for (int i = 0; i < 4; i++) begin
            pready = i == 3;
            chk("t3_psel", psel, 1);
            chk("t3_pen", pen, 1);
            chk("t3_paddr", paddr, 32'h8);
            chk("t3_no_early_rsp", rsp_valid, 0);
            cyc();
        end
        pready = 1'b0;
        rv_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            rv_cnt += int'(rsp_valid);
            cyc();
        end
        chk("t3_rsp_once", rv_cnt, 1);
        // second request held while busy
        pready = 1'b1;
        issue(1'b1, 32'hC, 32'h11111111);
        cyc();
        issue(1'b0, 32'h8, 32'h0);
        chk("t4_busy1", req_ready, 0);
        cyc();
        chk("t4_busy2", req_ready, 0);
        cyc();
        chk("t4_rsp_valid", rsp_valid, 1);
        chk("t4_ready_again", req_ready, 1);
        cyc();
        req_valid = 1'b0;
        chk("t4_b_psel", psel, 1);
        chk("t4_b_pen", pen, 0);
        chk("t4_b_paddr", paddr, 32'h8);
        chk("t4_b_pwrite", pwrite, 0);
        cyc();
        cyc();
        chk("t4_b_rsp", rsp_valid, 1);
        chk("t4_b_rdata", rsp_rdata, 32'hA5A5A5A5);
        cyc();
`ifdef APB_MASTER_TIMEOUT_EN
        pready = 1'b0;
        issue(1'b0, 32'h4, 32'h0);
        cyc();
        req_valid = 1'b0;
        cyc();
        for (int i = 0; i < TO; i++) begin
            chk("t6_wait_psel", psel, 1);
            chk("t6_wait_rsp", rsp_valid, 0);
            cyc();
        end
        chk("t6_rsp_valid", rsp_valid, 1);
        chk("t6_rsp_err", rsp_err, 1);
        chk("t6_psel", psel, 0);
        chk("t6_rdata_kept", rsp_rdata, 32'hA5A5A5A5);
        cyc();
`endif
        // reset during ACCESS
        pready = 1'b0;
        issue(1'b1, 32'h10, 32'h22222222);
        cyc();
        req_valid = 1'b0;
        cyc();
        chk("t5_in_access", pen, 1);
        #1 rst = 1'b0;
        #1;
        chk("t5_psel_async", psel, 0);
        chk("t5_pen_async", pen, 0);
        chk("t5_rsp_valid", rsp_valid, 0);
        cyc();
        rst = 1'b1;
        chk("t5_req_ready", req_ready, 1);
        rv_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            rv_cnt += int'(rsp_valid);
            cyc();
        end
        chk("t5_no_rsp", rv_cnt, 0);
        // randomized traffic, requests often held while busy
        rand_pready = 1'b1;
        for (int t = 0; t < 300; t++) begin
            issue(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)) << 2, $urandom);
            b = 0;
            while (!req_ready && b < 100) begin
                cyc();
                b++;
            end
            if (b >= 100) chk("rand_accept_bound", b, 0);
            cyc();
            if ($urandom_range(0, 1) == 1) begin
                req_valid = 1'b0;
                repeat ($urandom_range(0, 2)) cyc();
            end
        end
        req_valid = 1'b0;
        rand_pready = 1'b0;
        pready = 1'b1;
        repeat (8) cyc();
        chk("end_idle", req_ready, 1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
